// File: rtl/input_conditioner.sv
// Per-channel button conditioner: 2-flop synchronizer, debounce FSM, and
// registered level / press / release / long-press outputs.
module input_conditioner #(
   parameter int NB_SW       = 4,
   parameter int NB_DEB      = 20,
   parameter int DEB_CYCLES  = 1000,
   parameter int LONG_CYCLES = 50000
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_btn,
   output logic [NB_SW-1:0] o_btn,
   output logic [NB_SW-1:0] o_press,
   output logic [NB_SW-1:0] o_release,
   output logic [NB_SW-1:0] o_long,
   output logic             o_any
);

   typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_REL} state_e;

   localparam logic [NB_DEB-1:0] ONE      = NB_DEB'(1);
   localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEB_CYCLES - 1);
   localparam logic [NB_DEB-1:0] LONG_MAX = NB_DEB'(LONG_CYCLES);
   localparam logic [NB_DEB-1:0] LONG_PRE = NB_DEB'(LONG_CYCLES - 1);

   logic [NB_SW-1:0]  sync1_q, sync2_q;
   state_e            state_q [NB_SW];
   state_e            state_d [NB_SW];
   logic [NB_DEB-1:0] deb_q   [NB_SW];
   logic [NB_DEB-1:0] deb_d   [NB_SW];
   logic [NB_DEB-1:0] hold_q  [NB_SW];
   logic [NB_DEB-1:0] hold_d  [NB_SW];

   logic [NB_SW-1:0]  press_evt_d, press_evt_q;
   logic [NB_SW-1:0]  rel_evt_d, rel_evt_q;
   logic [NB_SW-1:0]  long_evt_d, long_evt_q;
   logic [NB_SW-1:0]  btn_d;
   logic [NB_SW-1:0]  o_btn_q, o_press_q, o_release_q, o_long_q;
   logic              o_any_q;

   // NOTE: every variable gets its default before the case so no latch is inferred.
   always_comb begin
      for (int ch = 0; ch < NB_SW; ch++) begin
         state_d[ch]     = state_q[ch];
         deb_d[ch]       = deb_q[ch];
         hold_d[ch]      = hold_q[ch];
         press_evt_d[ch] = 1'b0;
         rel_evt_d[ch]   = 1'b0;
         long_evt_d[ch]  = 1'b0;
         btn_d[ch]       = (state_q[ch] == HELD) || (state_q[ch] == CHK_REL);

         case (state_q[ch])
            IDLE: begin
               if (sync2_q[ch]) begin
                  state_d[ch] = CHK_PRESS;
                  deb_d[ch]   = '0;
               end
            end
            CHK_PRESS: begin
               if (!sync2_q[ch]) begin
                  state_d[ch] = IDLE;
               end else begin
                  deb_d[ch] = deb_q[ch] + ONE;
                  if (deb_q[ch] == DEB_LAST) begin
                     state_d[ch]     = HELD;
                     hold_d[ch]      = '0;
                     press_evt_d[ch] = 1'b1;
                  end
               end
            end
            HELD: begin
               if (!sync2_q[ch]) begin
                  state_d[ch] = CHK_REL;
                  deb_d[ch]   = '0;
               end else if (hold_q[ch] != LONG_MAX) begin
                  // Saturation at LONG_MAX is what keeps o_long to one pulse per press.
                  hold_d[ch] = hold_q[ch] + ONE;
                  if (hold_q[ch] == LONG_PRE) long_evt_d[ch] = 1'b1;
               end
            end
            CHK_REL: begin
               if (sync2_q[ch]) begin
                  state_d[ch] = HELD;
               end else begin
                  deb_d[ch] = deb_q[ch] + ONE;
                  if (deb_q[ch] == DEB_LAST) begin
                     state_d[ch]   = IDLE;
                     rel_evt_d[ch] = 1'b1;
                  end
               end
            end
            default: state_d[ch] = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         press_evt_q <= '0;
         rel_evt_q   <= '0;
         long_evt_q  <= '0;
         o_btn_q     <= '0;
         o_press_q   <= '0;
         o_release_q <= '0;
         o_long_q    <= '0;
         o_any_q     <= 1'b0;
         for (int ch = 0; ch < NB_SW; ch++) begin
            state_q[ch] <= IDLE;
            deb_q[ch]   <= '0;
            hold_q[ch]  <= '0;
         end
      end else begin
         sync1_q     <= i_btn;
         sync2_q     <= sync1_q;
         press_evt_q <= press_evt_d;
         rel_evt_q   <= rel_evt_d;
         long_evt_q  <= long_evt_d;
         o_btn_q     <= btn_d;
         o_press_q   <= press_evt_q;
         o_release_q <= rel_evt_q;
         o_long_q    <= long_evt_q;
         o_any_q     <= |press_evt_q;
         for (int ch = 0; ch < NB_SW; ch++) begin
            state_q[ch] <= state_d[ch];
            deb_q[ch]   <= deb_d[ch];
            hold_q[ch]  <= hold_d[ch];
         end
      end
   end

   assign o_btn     = o_btn_q;
   assign o_press   = o_press_q;
   assign o_release = o_release_q;
   assign o_long    = o_long_q;
   assign o_any     = o_any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is active.
module tb_input_conditioner;

   localparam int NB_SW = 4;
   localparam int LAT   = 8;   // drive at negedge c -> pulse seen at negedge c+8

   logic             clock = 1'b0;
   logic             i_reset;
   logic [NB_SW-1:0] i_btn;
   logic [NB_SW-1:0] o_btn, o_press, o_release, o_long;
   logic             o_any;

   input_conditioner #(
      .NB_SW(NB_SW), .NB_DEB(20), .DEB_CYCLES(4), .LONG_CYCLES(16)
   ) dut (
      .clock(clock), .i_reset(i_reset), .i_btn(i_btn),
      .o_btn(o_btn), .o_press(o_press), .o_release(o_release),
      .o_long(o_long), .o_any(o_any)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int               at;
      logic [NB_SW-1:0] press;
      logic [NB_SW-1:0] rel;
      logic [NB_SW-1:0] lng;
   } event_t;

   event_t sb[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int at, input logic [NB_SW-1:0] p,
                       input logic [NB_SW-1:0] r, input logic [NB_SW-1:0] l);
      event_t e;
      e.at = at; e.press = p; e.rel = r; e.lng = l;
      sb.push_back(e);
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Monitor
   always @(negedge clock) begin
      if (!i_reset && ((|o_press) || (|o_release) || (|o_long) || o_any)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {o_press, o_release, o_long, 3'b0, o_any}, 32'h0);
         end else begin
            event_t e;
            e = sb.pop_front();
            check($sformatf("pulse_cycle_%0d", e.at), cyc, e.at);
            check($sformatf("o_press_%0d", e.at), 32'(o_press), 32'(e.press));
            check($sformatf("o_release_%0d", e.at), 32'(o_release), 32'(e.rel));
            check($sformatf("o_long_%0d", e.at), 32'(o_long), 32'(e.lng));
            check($sformatf("o_any_%0d", e.at), 32'(o_any), 32'(|e.press));
         end
      end
   end

   initial begin
      int c;
      logic [8:0] pat;

      i_reset = 1'b1;
      i_btn   = '0;
      repeat (3) @(negedge clock);
      check("rst_o_btn", 32'(o_btn), 0);
      check("rst_o_press", 32'(o_press), 0);
      check("rst_o_release", 32'(o_release), 0);
      check("rst_o_long", 32'(o_long), 0);
      check("rst_o_any", 32'(o_any), 0);
      i_reset = 1'b0;
      repeat (3) @(negedge clock);

      // Clean press on channel 0, held 12 cycles
      c = cyc;
      i_btn[0] = 1'b1;
      push(c + LAT, 4'b0001, 4'b0000, 4'b0000);
      push(c + 12 + LAT, 4'b0000, 4'b0001, 4'b0000);
      at_cyc(c + 7);  check("clean_btn_before", 32'(o_btn[0]), 0);
      at_cyc(c + 8);  check("clean_btn_on", 32'(o_btn[0]), 1);
      at_cyc(c + 12); i_btn[0] = 1'b0;
      at_cyc(c + 19); check("clean_btn_still", 32'(o_btn[0]), 1);
      at_cyc(c + 20); check("clean_btn_off", 32'(o_btn[0]), 0);
      at_cyc(c + 30);

      // Glitch on channel 2: three cycles high
      c = cyc;
      i_btn[2] = 1'b1;
      at_cyc(c + 3);  i_btn[2] = 1'b0;
      at_cyc(c + 8);  check("glitch_btn_a", 32'(o_btn[2]), 0);
      at_cyc(c + 12); check("glitch_btn_b", 32'(o_btn[2]), 0);
      at_cyc(c + 20);

      // Bounce on channel 1, then stable high
      c = cyc;
      pat = 9'b011011011;
      push(c + 9 + LAT, 4'b0010, 4'b0000, 4'b0000);
      push(c + 25 + LAT, 4'b0000, 4'b0010, 4'b0000);
      for (int p = 0; p < 9; p++) begin
         at_cyc(c + p);
         i_btn[1] = pat[p];
      end
      at_cyc(c + 9);  i_btn[1] = 1'b1;
      at_cyc(c + 16); check("bounce_btn_before", 32'(o_btn[1]), 0);
      at_cyc(c + 17); check("bounce_btn_on", 32'(o_btn[1]), 1);
      at_cyc(c + 25); i_btn[1] = 1'b0;
      at_cyc(c + 45);

      // Long press on channel 2, 40 cycles
      c = cyc;
      i_btn[2] = 1'b1;
      push(c + LAT, 4'b0100, 4'b0000, 4'b0000);
      push(c + LAT + 16, 4'b0000, 4'b0000, 4'b0100);
      push(c + 40 + LAT, 4'b0000, 4'b0100, 4'b0000);
      at_cyc(c + 30); check("long_btn_held", 32'(o_btn[2]), 1);
      at_cyc(c + 40); i_btn[2] = 1'b0;
      at_cyc(c + 60);

      // Simultaneous press on channels 0 and 3
      c = cyc;
      i_btn = 4'b1001;
      push(c + LAT, 4'b1001, 4'b0000, 4'b0000);
      push(c + 10 + LAT, 4'b0000, 4'b1001, 4'b0000);
      at_cyc(c + 10); i_btn = 4'b0000;
      at_cyc(c + 30);

      // Reset while channel 0 is held
      c = cyc;
      i_btn[0] = 1'b1;
      push(c + LAT, 4'b0001, 4'b0000, 4'b0000);
      at_cyc(c + 12);
      check("rsthold_btn_before", 32'(o_btn[0]), 1);
      i_reset = 1'b1;
      #1;
      check("rsthold_btn_async", 32'(o_btn), 0);
      at_cyc(c + 14);
      i_reset = 1'b0;
      push(c + 14 + LAT, 4'b0001, 4'b0000, 4'b0000);
      push(c + 30 + LAT, 4'b0000, 4'b0001, 4'b0000);
      at_cyc(c + 21); check("rsthold_btn_wait", 32'(o_btn[0]), 0);
      at_cyc(c + 22); check("rsthold_btn_again", 32'(o_btn[0]), 1);
      at_cyc(c + 30); i_btn[0] = 1'b0;

      // Drain outstanding expectations with a bounded wait
      for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clock);
      repeat (10) @(negedge clock);
      check("scoreboard_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter NB_SW, default 4, giving the number of independent button/switch channels.
REQ-002 The block SHALL have parameter NB_DEB, default 20, giving the width of the debounce and hold counters.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 1000, giving the number of stable cycles required (legal range 2 to 2^NB_DEB-1).
REQ-004 The block SHALL have parameter LONG_CYCLES, default 50000, giving the number of HELD cycles that make a long press (legal range DEB_CYCLES to 2^NB_DEB-1).
REQ-005 The block SHALL have port clock, input, width 1, the single system clock, rising edge.
REQ-006 The block SHALL have port i_reset, input, width 1; reset is asynchronous and active-high.
REQ-007 The block SHALL have port i_btn, input, width NB_SW, raw asynchronous bouncing button levels.
REQ-008 The block SHALL have port o_btn, output, width NB_SW, the debounced level per channel.
REQ-009 The block SHALL have port o_press, output, width NB_SW, a one-cycle pulse on each debounced 0->1 transition.
REQ-010 The block SHALL have port o_release, output, width NB_SW, a one-cycle pulse on each debounced 1->0 transition.
REQ-011 The block SHALL have port o_long, output, width NB_SW, a one-cycle pulse when a channel has been held LONG_CYCLES.
REQ-012 The block SHALL have port o_any, output, width 1, equal to the OR-reduction of o_press.

Function
REQ-013 Each i_btn bit SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the synchronized level (sync).
REQ-014 Each channel SHALL run an independent FSM with states IDLE, CHK_PRESS, HELD and CHK_REL.
REQ-015 IDLE with sync=1 SHALL go to CHK_PRESS with the debounce counter cleared to 0.
REQ-016 CHK_PRESS with sync=0 SHALL return to IDLE with no output pulse.
REQ-017 CHK_PRESS with sync=1 SHALL increment the debounce counter, and SHALL go to HELD when the count equals DEB_CYCLES-1.
REQ-018 Entering HELD SHALL clear the hold counter.
REQ-019 HELD with sync=0 SHALL go to CHK_REL with the debounce counter cleared to 0.
REQ-020 HELD with sync=1 SHALL increment the hold counter, saturating at LONG_CYCLES.
REQ-021 CHK_REL with sync=1 SHALL return to HELD without clearing the hold counter and with no pulse.
REQ-022 CHK_REL with sync=0 SHALL increment the debounce counter, and SHALL go to IDLE when the count equals DEB_CYCLES-1.
REQ-023 o_btn SHALL be 1 exactly while the channel is in HELD or CHK_REL, and all outputs SHALL be registered.
REQ-024 o_press SHALL be high only in the first cycle of a HELD entry from CHK_PRESS, which is DEB_CYCLES+3 cycles after i_btn is first sampled high.
REQ-025 o_release SHALL be high only in the first cycle of an IDLE entry from CHK_REL, which is DEB_CYCLES+3 cycles after i_btn is first sampled low.
REQ-026 o_long SHALL pulse once in the cycle the hold counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after o_press, and SHALL not repeat until the next press.
REQ-027 Channels SHALL be fully independent, and simultaneous events on several channels SHALL assert their pulse bits in the same cycle.
REQ-028 Counters SHALL never wrap, since the debounce counter is bounded by the FSM and the hold counter saturates.

Reset
REQ-029 i_reset high SHALL immediately force synchronizers, counters, all FSMs to IDLE and all outputs to 0, including mid-debounce or mid-hold.
REQ-030 After i_reset deasserts, a button still held SHALL be treated as a new press and produce o_press DEB_CYCLES+3 cycles later, with no suppression.

Verification (DEB_CYCLES=4, LONG_CYCLES=16, NB_SW=4)
REQ-031 Clean press: i_btn[0] high 12 cycles then low -> o_press[0] one pulse 7 cycles after rise, o_btn[0]=1 until release, o_release[0] one pulse 7 cycles after fall.
REQ-032 Bounce: i_btn[1] pattern 1,1,0,1,1,0,1,1,0 then stable 1 -> exactly one o_press[1] and no o_release[1].
REQ-033 Glitch: i_btn[2] high 3 cycles then low -> o_btn, o_press, o_release and o_long all remain 0.
REQ-034 Long press: i_btn[2] held 40 cycles -> o_press[2] once, o_long[2] exactly once 16 cycles later, then a single o_release[2] after release.
REQ-035 Simultaneous: i_btn=4'b1001 asserted in the same cycle -> o_press=4'b1001 for one cycle and o_any=1 in that cycle only.
REQ-036 Reset mid-hold: i_reset pulsed while channel 0 is HELD -> o_btn=0 with no o_release; with i_btn[0] still high, o_press[0] recurs 7 cycles after reset release.
